// File: rtl/linear_step_pkg.sv
// Shared types for the linear step generator: step payload encodings, FSM states
// and the derived step-count width.
package linear_step_pkg;

    typedef enum logic {
        AXIS_X = 1'b0,
        AXIS_Y = 1'b1
    } step_axis_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } step_dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Three guard bits cover |dx|+|dy| and the signed decision term without overflow.
    function automatic int step_bits(input int num_bits);
        return num_bits + 3;
    endfunction

endpackage

// File: rtl/linear_step_decider.sv
// Combinational step decision: picks the axis of the next unit step from the
// current progress and error term, and produces the post-step counters.
module linear_step_decider
    import linear_step_pkg::*;
#(
    parameter int STEP_BITS = 11
) (
    input  logic        [STEP_BITS-1:0] cx,
    input  logic        [STEP_BITS-1:0] cy,
    input  logic        [STEP_BITS-1:0] adx,
    input  logic        [STEP_BITS-1:0] ady,
    input  logic signed [STEP_BITS-1:0] d,
    input  step_dir_t                   sx,
    input  step_dir_t                   sy,
    output step_axis_t                  axis,
    output step_dir_t                   dir,
    output logic        [STEP_BITS-1:0] cx_next,
    output logic        [STEP_BITS-1:0] cy_next,
    output logic signed [STEP_BITS-1:0] d_next
);

    logic d_nonpos;

    always_comb begin
        d_nonpos = d[STEP_BITS-1] || (d == '0);

        // Exhausted axes take priority; otherwise D==0 breaks the tie toward X.
        if (cx == adx) begin
            axis = AXIS_Y;
        end else if (cy == ady) begin
            axis = AXIS_X;
        end else if (d_nonpos) begin
            axis = AXIS_X;
        end else begin
            axis = AXIS_Y;
        end

        dir     = (axis == AXIS_X) ? sx : sy;
        cx_next = cx;
        cy_next = cy;
        d_next  = d;
        if (axis == AXIS_X) begin
            cx_next = cx + 1'b1;
            d_next  = d + $signed(ady);
        end else begin
            cy_next = cy + 1'b1;
            d_next  = d - $signed(adx);
        end
    end

endmodule

// File: rtl/linear_step_generator.sv
// Converts a start/end segment into a handshaked stream of unit Manhattan steps,
// with a one-cycle done pulse once the last step has been taken.
module linear_step_generator
    import linear_step_pkg::*;
#(
    parameter  int NUM_BITS  = 8,
    localparam int STEP_BITS = step_bits(NUM_BITS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [NUM_BITS-1:0]  start_x,
    input  logic signed [NUM_BITS-1:0]  start_y,
    input  logic signed [NUM_BITS-1:0]  end_x,
    input  logic signed [NUM_BITS-1:0]  end_y,
    input  logic                        seg_valid,
    output logic                        seg_ready,
    output logic                        step_valid,
    input  logic                        step_ready,
    output logic                        step_axis,
    output logic                        step_dir,
    output logic        [STEP_BITS-1:0] steps_left,
    output logic                        done
);

    state_t state, state_next;

    logic        [STEP_BITS-1:0] adx_q, ady_q, cx_q, cy_q;
    logic signed [STEP_BITS-1:0] d_q;
    step_dir_t                   sx_q, sy_q;

    logic signed [STEP_BITS-1:0] dx, dy;
    logic        [STEP_BITS-1:0] adx_in, ady_in, seg_len;

    step_axis_t                  dec_axis;
    step_dir_t                   dec_dir;
    logic        [STEP_BITS-1:0] cx_next, cy_next;
    logic signed [STEP_BITS-1:0] d_next;

    always_comb begin
        dx      = {{(STEP_BITS-NUM_BITS){end_x[NUM_BITS-1]}}, end_x}
                - {{(STEP_BITS-NUM_BITS){start_x[NUM_BITS-1]}}, start_x};
        dy      = {{(STEP_BITS-NUM_BITS){end_y[NUM_BITS-1]}}, end_y}
                - {{(STEP_BITS-NUM_BITS){start_y[NUM_BITS-1]}}, start_y};
        adx_in  = dx[STEP_BITS-1] ? -dx : dx;
        ady_in  = dy[STEP_BITS-1] ? -dy : dy;
        seg_len = adx_in + ady_in;
    end

    linear_step_decider #(
        .STEP_BITS(STEP_BITS)
    ) u_decider (
        .cx      (cx_q),
        .cy      (cy_q),
        .adx     (adx_q),
        .ady     (ady_q),
        .d       (d_q),
        .sx      (sx_q),
        .sy      (sy_q),
        .axis    (dec_axis),
        .dir     (dec_dir),
        .cx_next (cx_next),
        .cy_next (cy_next),
        .d_next  (d_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        seg_ready  = 1'b0;
        step_valid = 1'b0;
        done       = 1'b0;
        step_axis  = 1'b0;
        step_dir   = 1'b0;
        unique case (state)
            IDLE: begin
                seg_ready = 1'b1;
                if (seg_valid) begin
                    state_next = (seg_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                step_valid = 1'b1;
                step_axis  = (dec_axis == AXIS_Y);
                step_dir   = (dec_dir == DIR_NEG);
                if (step_ready && (steps_left == STEP_BITS'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adx_q      <= '0;
            ady_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            d_q        <= '0;
            sx_q       <= DIR_POS;
            sy_q       <= DIR_POS;
            steps_left <= '0;
        end else begin
            if ((state == IDLE) && seg_valid) begin
                adx_q      <= adx_in;
                ady_q      <= ady_in;
                cx_q       <= '0;
                cy_q       <= '0;
                d_q        <= '0;
                sx_q       <= dx[STEP_BITS-1] ? DIR_NEG : DIR_POS;
                sy_q       <= dy[STEP_BITS-1] ? DIR_NEG : DIR_POS;
                steps_left <= seg_len;
            end else if ((state == RUN) && step_ready) begin
                cx_q       <= cx_next;
                cy_q       <= cy_next;
                d_q        <= d_next;
                steps_left <= steps_left - 1'b1;
            end
        end
    end

endmodule
